// File: rtl/fht_but_feeder.sv
// fht_but_feeder: operand/twiddle sequencer for one radix-2 FHT stage over N = 2**LOG_N points.
// Per butterfly it issues x1/x2 read addresses, then x0 and sin/cos one cycle later, and
// returns the matching y0/y1 write-back addresses WB_DLY cycles after the x1/x2 issue.
// Data is ping-pong: reads from bank oBANK, writes to bank ~oBANK.
//
// Optional feature: define FHT_AUTO_STAGE_EN to run stages 0..LOG_N-1 from one iSTART
// (iSTAGE ignored, oBANK toggles per stage, single oDONE after the last stage).
//
// Ports:
//   iCLK, iRESET         clock, asynchronous active-high reset
//   iSTART, iSTAGE       start pulse (sampled in idle only) and stage index
//   oBUSY, oDONE         busy from accepted start through the oDONE cycle; done pulse
//   oBANK                read bank
//   oRD_EN, oRD_ADDR_1/2 x1/x2 read strobe and addresses
//   oRD_EN_0, oRD_ADDR_0 x0 read strobe and address, one cycle after x1/x2
//   oSIN, oCOS           signed twiddles, aligned with x0
//   oWR_EN, oWR_ADDR_0/1 write-back strobe and y0/y1 destinations
module fht_but_feeder #(
    parameter int unsigned LOG_N  = 4,
    parameter int unsigned W_BIT  = 16,
    parameter int unsigned WB_DLY = 3
) (
    input  logic                       iCLK,
    input  logic                       iRESET,
    input  logic                       iSTART,
    input  logic [$clog2(LOG_N)-1:0]   iSTAGE,
    output logic                       oBUSY,
    output logic                       oDONE,
    output logic                       oBANK,
    output logic                       oRD_EN,
    output logic [LOG_N-1:0]           oRD_ADDR_1,
    output logic [LOG_N-1:0]           oRD_ADDR_2,
    output logic                       oRD_EN_0,
    output logic [LOG_N-1:0]           oRD_ADDR_0,
    output logic signed [W_BIT-1:0]    oSIN,
    output logic signed [W_BIT-1:0]    oCOS,
    output logic                       oWR_EN,
    output logic [LOG_N-1:0]           oWR_ADDR_0,
    output logic [LOG_N-1:0]           oWR_ADDR_1
);

    localparam int unsigned SW   = $clog2(LOG_N);
    localparam int unsigned MW   = LOG_N - 1;          // butterfly counter / ROM index width
    localparam int unsigned Q    = 1 << (LOG_N - 2);   // N/4
    localparam int unsigned FW   = $clog2(WB_DLY + 1);
    localparam int          MaxW = 2 ** (W_BIT - 1) - 1;
    localparam real         Pi   = 3.14159265358979323846;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    // Quarter-wave sine table; entries above N/4 are never addressed.
    logic signed [W_BIT-1:0] lut [2**MW];
    for (genvar m = 0; m < 2**MW; m++) begin : g_lut
        localparam real Ang = 2.0 * Pi * real'(m) / real'(2 ** LOG_N);
        localparam int  Val = $rtoi(real'(MaxW) * $sin(Ang) + 0.5);
        assign lut[m] = W_BIT'(Val);
    end

    state_e           state_q, state_d;
    logic [MW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [FW-1:0]    fl_q, fl_d;
    logic             bank_q, busy_q, done_q, done_d, issue;

`ifdef FHT_AUTO_STAGE_EN
    logic unused_stage;
    assign unused_stage = ^iSTAGE;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        fl_d    = fl_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (iSTART) begin
                    cnt_d = '0;
                    fl_d  = '0;
`ifdef FHT_AUTO_STAGE_EN
                    stage_d = '0;
                    state_d = StRun;
`else
                    stage_d = iSTAGE;
                    if (32'(iSTAGE) < LOG_N) begin
                        state_d = StRun;
                    end else begin
                        // Out-of-range stage: no strobes, oDONE two cycles after start.
                        state_d = StFlush;
                        fl_d    = FW'(WB_DLY);
                    end
`endif
                end
            end
            StRun: begin
                issue = 1'b1;
                cnt_d = cnt_q + MW'(1);
                if (&cnt_q) begin
                    state_d = StFlush;
                    fl_d    = '0;
                end
            end
            StFlush: begin
                // Stay here through the oDONE cycle so a start there is ignored.
                if (done_q) begin
                    state_d = StIdle;
                end else if (fl_q == FW'(WB_DLY)) begin
`ifdef FHT_AUTO_STAGE_EN
                    if (32'(stage_q) < LOG_N - 1) begin
                        stage_d = stage_q + SW'(1);
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
`else
                    done_d = 1'b1;
`endif
                end else begin
                    fl_d = fl_q + FW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Butterfly address and twiddle-index generation for the current cnt.
    logic [LOG_N-1:0] h, b, kw, x0, x1, x2;
    logic [MW-1:0]    k, j, sin_m, cos_m;
    logic             neg;

    always_comb begin
        h  = LOG_N'(1) << stage_q;
        k  = cnt_q & MW'(h - LOG_N'(1));
        kw = {1'b0, k};
        b  = ({1'b0, cnt_q} >> stage_q) << 1 << stage_q;
        x0 = b + kw;
        x1 = b + h + kw;
        x2 = b + h + ((h - kw) & (h - LOG_N'(1)));
        // j = k * N/2**(s+1); k < 2**s so j fits in MW bits.
        j  = k << (MW - 32'(stage_q));
        if (j <= MW'(Q)) begin
            sin_m = j;
            cos_m = MW'(Q) - j;
            neg   = 1'b0;
        end else begin
            sin_m = MW'(2 * Q) - j;   // N/2 - j, modulo 2**MW
            cos_m = j - MW'(Q);
            neg   = 1'b1;
        end
    end

    logic                    rd_en_q, rd_en0_q, neg_q;
    logic [LOG_N-1:0]        rd_a1_q, rd_a2_q, x0_q, rd_a0_q;
    logic [MW-1:0]           sin_m_q, cos_m_q;
    logic signed [W_BIT-1:0] sin_q, cos_q;
    logic [WB_DLY-1:0]       wr_v_q;
    logic [LOG_N-1:0]        wr_y0_q [WB_DLY];
    logic [LOG_N-1:0]        wr_y1_q [WB_DLY];

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            stage_q  <= '0;
            fl_q     <= '0;
            bank_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_a1_q  <= '0;
            rd_a2_q  <= '0;
            x0_q     <= '0;
            sin_m_q  <= '0;
            cos_m_q  <= '0;
            neg_q    <= 1'b0;
            rd_en0_q <= 1'b0;
            rd_a0_q  <= '0;
            sin_q    <= '0;
            cos_q    <= '0;
            wr_v_q   <= '0;
            for (int i = 0; i < WB_DLY; i++) begin
                wr_y0_q[i] <= '0;
                wr_y1_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            fl_q     <= fl_d;
            bank_q   <= stage_d[0];
            busy_q   <= (state_d != StIdle);
            done_q   <= done_d;
            rd_en_q  <= issue;
            if (issue) begin
                rd_a1_q <= x1;
                rd_a2_q <= x2;
                x0_q    <= x0;
                sin_m_q <= sin_m;
                cos_m_q <= cos_m;
                neg_q   <= neg;
            end
            rd_en0_q <= rd_en_q;
            if (rd_en_q) begin
                rd_a0_q <= x0_q;
                sin_q   <= lut[sin_m_q];
                cos_q   <= neg_q ? -lut[cos_m_q] : lut[cos_m_q];
            end
            wr_v_q     <= {wr_v_q[WB_DLY-2:0], rd_en_q};
            wr_y0_q[0] <= x0_q;
            wr_y1_q[0] <= rd_a1_q;
            for (int i = 1; i < WB_DLY; i++) begin
                wr_y0_q[i] <= wr_y0_q[i-1];
                wr_y1_q[i] <= wr_y1_q[i-1];
            end
        end
    end

    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oBANK      = bank_q;
    assign oRD_EN     = rd_en_q;
    assign oRD_ADDR_1 = rd_a1_q;
    assign oRD_ADDR_2 = rd_a2_q;
    assign oRD_EN_0   = rd_en0_q;
    assign oRD_ADDR_0 = rd_a0_q;
    assign oSIN       = sin_q;
    assign oCOS       = cos_q;
    assign oWR_EN     = wr_v_q[WB_DLY-1];
    assign oWR_ADDR_0 = wr_y0_q[WB_DLY-1];
    assign oWR_ADDR_1 = wr_y1_q[WB_DLY-1];

endmodule
